// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed little-endian byte stream, writes the payload
// through a word-write port and releases the CPU reset only after the checksum matches.
module prog_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter logic [31:0] MAGIC  = 32'h52564C44
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  output logic        o_cpu_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StIdle, StHdrBase, StHdrLen, StPayload, StWrite, StCheck, StDone, StErr
  } state_e;

  localparam logic [32:0] MemWords = 33'd1 << ADDR_W;

  state_e      r_state, w_state_d;
  logic [31:0] r_win;
  logic [1:0]  r_cnt;
  logic [31:0] r_base;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [31:0] r_acc;

  logic        r_rx_ready, r_mem_we, r_cpu_rst, r_busy, r_done, r_err;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr, r_mem_wdata;

  logic        w_accept, w_last_byte, w_range_err;
  logic [31:0] w_win_nxt, w_idx_nxt;
  logic [32:0] w_range_sum;
  logic        w_rx_ready_d, w_mem_we_d, w_cpu_rst_d, w_busy_d, w_done_d, w_err_d;
  logic [3:0]  w_mem_be_d;

  assign w_accept    = i_rx_valid & r_rx_ready;
  // Newest byte enters at [31:24], so four shifts leave a little-endian word in place.
  assign w_win_nxt   = {i_rx_data, r_win[31:8]};
  assign w_last_byte = w_accept && (r_cnt == 2'd3);
  assign w_idx_nxt   = r_idx + 32'd1;

  // 33-bit sum so a frame ending exactly at the top of memory is still accepted.
  assign w_range_sum = {{(33 - ADDR_W){1'b0}}, r_base[ADDR_W+1:2]} + {1'b0, w_win_nxt};
  assign w_range_err = (w_range_sum > MemWords) || (r_base[31:ADDR_W+2] != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept && (w_win_nxt == MAGIC)) w_state_d = StHdrBase;
      end
      StHdrBase: begin
        if (w_last_byte) w_state_d = (w_win_nxt[1:0] != 2'b00) ? StErr : StHdrLen;
      end
      StHdrLen: begin
        if (w_last_byte) begin
          if (w_range_err)              w_state_d = StErr;
          else if (w_win_nxt == 32'd0)  w_state_d = StCheck;
          else                          w_state_d = StPayload;
        end
      end
      StPayload: begin
        if (w_last_byte) w_state_d = StWrite;
      end
      StWrite: begin
        w_state_d = (w_idx_nxt < r_len) ? StPayload : StCheck;
      end
      StCheck: begin
        if (w_last_byte) w_state_d = (w_win_nxt == r_acc) ? StDone : StErr;
      end
      StDone:  w_state_d = StDone;
      StErr:   w_state_d = StErr;
      default: w_state_d = StErr;
    endcase
  end

  always_comb begin
    w_rx_ready_d = 1'b0;
    w_mem_we_d   = 1'b0;
    w_busy_d     = 1'b0;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    w_cpu_rst_d  = 1'b1;
    unique case (w_state_d)
      StIdle:    w_rx_ready_d = 1'b1;
      StHdrBase,
      StHdrLen,
      StPayload,
      StCheck: begin
        w_rx_ready_d = 1'b1;
        w_busy_d     = 1'b1;
      end
      StWrite: begin
        w_mem_we_d = 1'b1;
        w_busy_d   = 1'b1;
      end
      StDone: begin
        w_done_d    = 1'b1;
        w_cpu_rst_d = 1'b0;
      end
      StErr:     w_err_d = 1'b1;
      default:   w_err_d = 1'b1;
    endcase
    w_mem_be_d = w_mem_we_d ? 4'hf : 4'h0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win       <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win <= w_win_nxt;
        if (r_state != StIdle) r_cnt <= r_cnt + 2'd1;
      end
      if ((r_state == StHdrBase) && w_last_byte) r_base <= w_win_nxt;
      if ((r_state == StHdrLen) && w_last_byte) begin
        r_len <= w_win_nxt;
        r_idx <= '0;
        r_acc <= '0;
      end
      if (r_state == StWrite) begin
        r_acc <= r_acc + r_win;
        r_idx <= w_idx_nxt;
      end
      if (w_state_d == StWrite) begin
        r_mem_addr  <= r_base + {r_idx[29:0], 2'b00};
        r_mem_wdata <= w_win_nxt;
      end
      r_rx_ready <= w_rx_ready_d;
      r_mem_we   <= w_mem_we_d;
      r_mem_be   <= w_mem_be_d;
      r_cpu_rst  <= w_cpu_rst_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits upstream of the CPU and its memories. It receives a framed byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit words. It writes the payload into instruction/data memory through a word-write port and holds the CPU in reset until the frame checks clean. On a checksum or header error it keeps the CPU in reset and flags the error.

## Interface
- Parameters:
  - `ADDR_W`, default 14: word-address width of the target memory (2^ADDR_W words).
  - `MAGIC`, default 32'h52564C44: frame start word.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rx_valid` input 1: a byte is offered on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader accepts the byte this cycle.
- `mem_we` output 1: one-cycle memory write strobe.
- `mem_addr` output 32: byte address of the write; always word aligned.
- `mem_wdata` output 32: write data.
- `mem_be` output 4: byte enables; 4'hf whenever `mem_we` = 1, else 4'h0.
- `cpu_rst` output 1: active-high reset to the CPU.
- `busy` output 1: a frame is in progress (past magic detection).
- `done` output 1: load succeeded; sticky.
- `err` output 1: load failed; sticky until `rst`.

## Operation
- **Byte transfer:** a byte is accepted on a rising edge with `rx_valid` and `rx_ready` both 1. Bytes offered while `rx_ready` = 0 are not consumed; the source holds them.
- **Frame format** (all words little-endian, byte 0 = bits 7:0), in order:
  - `MAGIC`
  - `BASE`: byte address.
  - `N`: word count.
  - N payload words.
  - `CSUM`: sum of the payload words mod 2^32.
- **States:** IDLE, HDR_BASE, HDR_LEN, PAYLOAD, WRITE, CHECK, DONE, ERR.
- **IDLE:**
  - Shifts every accepted byte into a 32-bit sliding window, newest byte into [31:24].
  - When the window equals `MAGIC`, moves to HDR_BASE. This resyncs on any garbage prefix.
- **Byte counter:** HDR_BASE, HDR_LEN, PAYLOAD and CHECK each collect 4 bytes with a 2-bit byte counter.
- **After BASE:**
  - If `BASE[1:0]` != 0, go to ERR.
  - Otherwise go to HDR_LEN.
- **After N:**
  - If `BASE[ADDR_W+1:2] + N` > 2^ADDR_W (computed in 33 bits, no wrap) or `BASE[31:ADDR_W+2]` != 0, go to ERR.
  - Else if N = 0, go to CHECK.
  - Else go to PAYLOAD, with word index 0 and checksum accumulator 0.
- **PAYLOAD:** on the 4th byte go to WRITE. In WRITE (exactly one cycle):
  - `mem_we` = 1, `mem_addr` = `BASE` + 4·index, `mem_wdata` = the assembled word.
  - The accumulator adds the word and the index increments.
  - Next state is PAYLOAD if index+1 < N, else CHECK.
- **CHECK:** on the 4th byte, go to DONE if the received word equals the accumulator, else ERR.
- **DONE and ERR:** terminal. Only `rst` leaves them.
- **Output by state:**
  - `rx_ready` = 1 in IDLE, HDR_BASE, HDR_LEN, PAYLOAD and CHECK; 0 in WRITE, DONE and ERR.
  - `busy` = 1 in HDR_BASE through CHECK.
  - `done` = 1 only in DONE; `err` = 1 only in ERR.
  - `cpu_rst` = 0 only in DONE.
- **Reset mid-operation:** asserting `rst` at any point returns to IDLE and clears the window, counters and accumulator. Memory already written is left as is. `cpu_rst` returns to 1.

## Timing
- **Reset values:**
  - `rx_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_be` = 0.
  - `cpu_rst` = 1, `busy` = 0, `done` = 0, `err` = 0.
- **Registered outputs:** all outputs are registered and decode the next state. `rx_ready` first rises on the 1st edge after `rst` deasserts.
- **Write latency:** 4th payload byte accepted at edge k, so `mem_we` is high from edge k to edge k+1, and `rx_ready` is 0 in that same cycle. Peak throughput is one word per 5 cycles.
- **Header decisions:** header checks and state changes take effect on the edge that accepts the 4th byte of the field.
- **End of frame:** `CSUM`'s 4th byte accepted at edge k, so `cpu_rst` falls (or `err` rises) after edge k. `rx_ready` is 0 from then on.
- **Arithmetic:** the accumulator and address add wrap mod 2^32; the range check guarantees the address never wraps.

## Test plan
- **Good load:** bytes 44 4C 56 52, `BASE` = 0, `N` = 2, words 0x00000013 and 0x00100093, `CSUM` 0x001000A6 -> writes to addresses 0x0 and 0x4 with `mem_be` = f. `done` = 1, `cpu_rst` = 0, `rx_ready` = 0.
- **Bad checksum:** same frame with `CSUM` 0x001000A7 -> both writes occur, then `err` = 1, `cpu_rst` stays 1, `rx_ready` = 0, and further bytes are ignored.
- **Resync:** AA BB 44 44 4C 56 52 followed by a valid `N` = 0 frame with `CSUM` 0 -> magic detected, no `mem_we`, `done` = 1.
- **Header errors:**
  - `BASE` = 0x00000002 -> `err` after `BASE`'s 4th byte.
  - With `ADDR_W` = 14, `BASE` = 0xFFF8 and `N` = 3 -> `err` after `N`'s 4th byte, with zero writes.
- **Backpressure and gaps:** random `rx_valid` gaps, plus `rx_valid` held high through WRITE -> no byte is lost or duplicated, and the checksum still matches.
- **Reset mid-payload:** `rst` low after the 1st word is written -> all outputs return to reset values immediately. A following complete frame loads correctly.
